// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: lane select, load extension and read-modify-write for sub-word stores.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int WORD_ADDR_W = 16
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        misalign_o,
    output logic        dm_wr_en_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic        dm_rd_en_o,
    input  logic [31:0] dm_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_MERGE_WR,
        S_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [WORD_ADDR_W+1:0] addr_q, addr_d;
    logic                   we_q, we_d;
    logic [1:0]             size_q, size_d;
    logic                   unsigned_q, unsigned_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   misalign_req;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^req_addr_i[31:WORD_ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign misalign_req = (req_size_i == 2'b01 && req_addr_i[0]) ||
                          (req_size_i[1] && req_addr_i[1:0] != 2'b00);
`else
    assign misalign_req = 1'b0;
`endif

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return {{24{~is_unsigned & b[7]}}, b};
            2'b01:   return {{16{~is_unsigned & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Only the addressed lane takes the new data; the rest comes from the read-back word.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lo);
        logic [31:0] r;
        r = old_word;
        case (size)
            2'b00:   r[{lo, 3'b000} +: 8] = wdata[7:0];
            2'b01:   if (lo[1]) r[31:16] = wdata[15:0]; else r[15:0] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments only; all next values come from always_comb.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d     = req_addr_i[WORD_ADDR_W+1:0];
                    we_d       = req_we_i;
                    size_d     = req_size_i;
                    unsigned_d = req_unsigned_i;
                    wdata_d    = req_wdata_i;
`ifdef MISALIGN_TRAP_EN
                    misalign_d = misalign_req;
`endif
                    if (misalign_req) begin
                        rsp_rdata_d = '0;
                        state_d     = S_RESP;
                    end else if (req_we_i && req_size_i[1]) begin
                        state_d = S_MERGE_WR;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                rdata_d = dm_rdata_i;
                if (we_q) begin
                    state_d = S_MERGE_WR;
                end else begin
                    rsp_rdata_d = load_extend(dm_rdata_i, size_q, addr_q[1:0], unsigned_q);
                    state_d     = S_RESP;
                end
            end
            S_MERGE_WR: state_d = S_IDLE;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        dm_rd_en_o  = (state_q == S_READ);
        dm_wr_en_o  = (state_q == S_MERGE_WR);
        rsp_valid_o = (state_q == S_MERGE_WR) || (state_q == S_RESP);
        dm_addr_o   = '0;
        dm_wdata_o  = '0;
        if (state_q == S_READ || state_q == S_MERGE_WR) begin
            dm_addr_o = {{(32 - WORD_ADDR_W){1'b0}}, addr_q[WORD_ADDR_W+1:2]};
        end
        if (state_q == S_MERGE_WR) begin
            dm_wdata_o = store_merge(rdata_q, wdata_q, size_q, addr_q[1:0]);
        end
        // Store responses carry no data; the load result register is left untouched.
        rsp_rdata_o = (state_q == S_MERGE_WR) ? '0 : rsp_rdata_q;
`ifdef MISALIGN_TRAP_EN
        misalign_o  = (state_q == S_RESP) && misalign_q;
`else
        misalign_o  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, corner sequences and a
// randomized run checked against a byte-addressed reference model.
module tb_load_store_unit;

    localparam int WORD_ADDR_W = 16;

    logic        sys_clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        misalign_o;
    logic        dm_wr_en_o;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_wdata_o;
    logic        dm_rd_en_o;
    logic [31:0] dm_rdata_i;

    always #5 sys_clk_i = ~sys_clk_i;

    load_store_unit #(.WORD_ADDR_W(WORD_ADDR_W)) dut (
        .sys_clk_i      (sys_clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .misalign_o     (misalign_o),
        .dm_wr_en_o     (dm_wr_en_o),
        .dm_addr_o      (dm_addr_o),
        .dm_wdata_o     (dm_wdata_o),
        .dm_rd_en_o     (dm_rd_en_o),
        .dm_rdata_i     (dm_rdata_i)
    );

    // Data memory: read data appears the cycle after the read strobe.
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge sys_clk_i) begin
        if (pre_we)     mem[pre_addr] <= pre_data;
        if (dm_wr_en_o) mem[dm_addr_o[7:0]] <= dm_wdata_o;
        if (dm_rd_en_o) dm_rdata_i <= mem[dm_addr_o[7:0]];
    end

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          overlap_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always @(negedge sys_clk_i) begin
        if (dm_wr_en_o) begin
            wr_cnt++;
            last_wr_addr = dm_addr_o;
            last_wr_data = dm_wdata_o;
        end
        if (dm_rd_en_o) rd_cnt++;
        if (dm_wr_en_o && dm_rd_en_o) overlap_cnt++;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic preload_word(input int idx, input logic [31:0] data);
        @(negedge sys_clk_i);
        pre_we   = 1'b1;
        pre_addr = idx[7:0];
        pre_data = data;
        @(negedge sys_clk_i);
        pre_we   = 1'b0;
    endtask

    // Issues one request and waits for its response; lat is the completion cycle counted
    // from the accept edge, or -1 when the unit never became ready or never responded.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic junk,
                          output int lat, output logic [31:0] rdata, output logic mis,
                          output logic wr_at_rsp);
        int guard;
        lat = -1;
        rdata = '0;
        mis = 1'b0;
        wr_at_rsp = 1'b0;
        guard = 0;
        @(negedge sys_clk_i);
        while (!req_ready_o && guard < 20) begin
            @(negedge sys_clk_i);
            guard++;
        end
        if (!req_ready_o) return;
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        @(posedge sys_clk_i);
        #1;
        if (junk) begin
            req_we_i       = $urandom_range(0, 1);
            req_size_i     = 2'($urandom_range(0, 3));
            req_unsigned_i = $urandom_range(0, 1);
            req_addr_i     = $urandom;
            req_wdata_i    = $urandom;
        end else begin
            req_valid_i = 1'b0;
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge sys_clk_i);
            if (rsp_valid_o) begin
                lat       = c;
                rdata     = rsp_rdata_o;
                mis       = misalign_o;
                wr_at_rsp = dm_wr_en_o;
                break;
            end
        end
        req_valid_i = 1'b0;
        #1;
    endtask

    // Reference model: little-endian byte array covering words 0..15.
    logic [7:0] ref_bytes [0:63];

    function automatic logic [31:0] model_load(input int a, input logic [1:0] size, input logic uns);
        longint v;
        int     base;
        case (size)
            2'b00: begin
                v = longint'(ref_bytes[a]);
                if (!uns && v >= 128) v -= 256;
            end
            2'b01: begin
                base = a - (a % 2);
                v = longint'(ref_bytes[base]) + 256 * longint'(ref_bytes[base+1]);
                if (!uns && v >= 32768) v -= 65536;
            end
            default: begin
                base = a - (a % 4);
                v = longint'(ref_bytes[base]) + 256 * longint'(ref_bytes[base+1]) +
                    65536 * longint'(ref_bytes[base+2]) + 16777216 * longint'(ref_bytes[base+3]);
            end
        endcase
        return v[31:0];
    endfunction

    task automatic model_store(input int a, input logic [1:0] size, input logic [31:0] wdata);
        int base;
        case (size)
            2'b00: ref_bytes[a] = wdata[7:0];
            2'b01: begin
                base = a - (a % 2);
                ref_bytes[base]   = wdata[7:0];
                ref_bytes[base+1] = wdata[15:8];
            end
            default: begin
                base = a - (a % 4);
                ref_bytes[base]   = wdata[7:0];
                ref_bytes[base+1] = wdata[15:8];
                ref_bytes[base+2] = wdata[23:16];
                ref_bytes[base+3] = wdata[31:24];
            end
        endcase
    endtask

    function automatic logic model_misaligned(input int a, input logic [1:0] size);
`ifdef MISALIGN_TRAP_EN
        return (size == 2'b01 && (a % 2) != 0) || (size[1] && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int          lat;
        logic [31:0] rdata;
        logic        mis;
        logic        wr_at;
        int          wr0;
        int          rd0;

        // Word 4 starts as 0x8899AABB; the table walks through loads and merges on it in order.
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFF88, 3};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000088, 3};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'h000000BB, 3};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF8899, 3};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h00008899, 3};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFFAABB, 3};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h123456CC, 32'h0,        3};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8899CCBB, 3};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h00007777, 32'h0,        3};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h7777CCBB, 3};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h00000055, 32'h0,        3};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'h00000077, 3};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'hFFFFFFCC, 3};
        vecs[13] = '{1'b0, 2'b10, 1'b1, 32'h10, 32'h0,        32'h5577CCBB, 3};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1};
        vecs[15] = '{1'b1, 2'b11, 1'b0, 32'h10, 32'h01020304, 32'h0,        1};
        vecs[16] = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h01020304, 3};

        rst_i          = 1'b1;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = '0;
        req_wdata_i    = '0;

        #1;
        check("reset_ready", 32'(req_ready_o), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("reset_rdata", rsp_rdata_o, 32'd0);
        check("reset_strobes", {30'd0, dm_wr_en_o, dm_rd_en_o}, 32'd0);
        check("reset_addr", dm_addr_o, 32'd0);
        check("reset_wdata", dm_wdata_o, 32'd0);
        check("reset_misalign", 32'(misalign_o), 32'd0);
        repeat (2) @(negedge sys_clk_i);
        rst_i = 1'b0;

        // Directed vector table.
        preload_word(4, 32'h8899AABB);
        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 1'b0,
                   lat, rdata, mis, wr_at);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_misalign", i), 32'(mis), 32'd0);
        end

        // Word store: single write cycle, no read, response in the same cycle.
        preload_word(4, 32'h8899AABB);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, lat, rdata, mis, wr_at);
        check("sw_latency", lat, 1);
        check("sw_wr_with_rsp", 32'(wr_at), 32'd1);
        check("sw_write_count", wr_cnt - wr0, 1);
        check("sw_read_count", rd_cnt - rd0, 0);
        check("sw_addr", last_wr_addr, 32'd4);
        check("sw_wdata", last_wr_data, 32'hDEADBEEF);

        // Reset while the sub-word store sits in WAIT: no write may follow.
        preload_word(4, 32'h8899AABB);
        @(negedge sys_clk_i);
        req_valid_i    = 1'b1;
        req_we_i       = 1'b1;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h11;
        req_wdata_i    = 32'h123456CC;
        @(posedge sys_clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge sys_clk_i);
        check("abort_read_strobe", 32'(dm_rd_en_o), 32'd1);
        @(negedge sys_clk_i);
        wr0 = wr_cnt;
        rst_i = 1'b1;
        #1;
        check("abort_ready", 32'(req_ready_o), 32'd1);
        check("abort_outputs", {29'd0, rsp_valid_o, dm_wr_en_o, dm_rd_en_o}, 32'd0);
        check("abort_addr_wdata", dm_addr_o | dm_wdata_o, 32'd0);
        check("abort_rdata", rsp_rdata_o, 32'd0);
        repeat (2) @(negedge sys_clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge sys_clk_i);
        check("abort_no_write", wr_cnt - wr0, 0);
        check("abort_word4_kept", mem[4], 32'h8899AABB);

        // Misaligned word load.
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0, lat, rdata, mis, wr_at);
`ifdef MISALIGN_TRAP_EN
        check("lw_mis_latency", lat, 1);
        check("lw_mis_flag", 32'(mis), 32'd1);
        check("lw_mis_rdata", rdata, 32'd0);
        check("lw_mis_reads", rd_cnt - rd0, 0);
`else
        check("lw_mis_latency", lat, 3);
        check("lw_mis_flag", 32'(mis), 32'd0);
        check("lw_mis_rdata", rdata, 32'h8899AABB);
        check("lw_mis_reads", rd_cnt - rd0, 1);
`endif
        check("lw_mis_writes", wr_cnt - wr0, 0);

        // Randomized traffic over words 0..15 with ignored high address bits and junk inputs while busy.
        for (int i = 0; i < 64; i++) ref_bytes[i] = 8'($urandom);
        for (int w = 0; w < 16; w++)
            preload_word(w, {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]});
        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [1:0]  size;
            logic        uns;
            int          a;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic        exp_mis;
            logic [31:0] exp_rdata;
            int          exp_lat;
            we    = $urandom_range(0, 1);
            size  = 2'($urandom_range(0, 3));
            uns   = $urandom_range(0, 1);
            a     = $urandom_range(0, 63);
            addr  = ($urandom & 32'hFFFC_0000) | 32'(a);
            wdata = $urandom;
            exp_mis   = model_misaligned(a, size);
            exp_lat   = exp_mis ? 1 : ((we && size[1]) ? 1 : 3);
            exp_rdata = (we || exp_mis) ? 32'd0 : model_load(a, size, uns);
            wr0 = wr_cnt;
            rd0 = rd_cnt;
            do_req(we, size, uns, addr, wdata, 1'b1, lat, rdata, mis, wr_at);
            check($sformatf("rnd%0d_latency", n), lat, exp_lat);
            check($sformatf("rnd%0d_rdata", n), rdata, exp_rdata);
            check($sformatf("rnd%0d_misalign", n), 32'(mis), 32'(exp_mis));
            check($sformatf("rnd%0d_writes", n), wr_cnt - wr0, (we && !exp_mis) ? 1 : 0);
            check($sformatf("rnd%0d_reads", n), rd_cnt - rd0, (!exp_mis && !(we && size[1])) ? 1 : 0);
            if (we && !exp_mis) begin
                check($sformatf("rnd%0d_wr_addr", n), last_wr_addr, 32'(a / 4));
                model_store(a, size, wdata);
            end
        end
        @(negedge sys_clk_i);
        for (int w = 0; w < 16; w++)
            check($sformatf("final_word%0d", w), mem[w],
                  {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]});
        check("rd_wr_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
